rtc_set_ctrl: RTL
=================

// Module: rtc_set_ctrl
// PURPOSE
//   Sequencing controller for the 24-hour BCD clock counter. Generates the 1 Hz count-enable tick from
//   the system clock. Runs the two-button time-set FSM (MODE/INC): captures the live HH:MM, lets the user
//   edit hours then minutes, and loads the result into the counter with seconds zeroed. Drives a per-digit
//   blank mask so the digit pair being edited blinks on the six 7-segment digits.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per tick_en pulse (1 Hz at 50 MHz); must be >= 2
//   BLINK_DIV  25_000_000  clk cycles per blink-phase toggle; must be >= 1
// PORTS
//   clk      in   1  system clock, all logic on rising edge
//   rst      in   1  asynchronous, active-low reset (0 = reset)
//   btn_mode in   1  MODE button, asynchronous level, active-high
//   btn_inc  in   1  INC button, asynchronous level, active-high
//   cur_hm   in   4  live hours tens (BCD) from the counter
//   cur_hl   in   4  live hours units (BCD)
//   cur_mm   in   4  live minutes tens (BCD)
//   cur_ml   in   4  live minutes units (BCD)
//   tick_en  out  1  one-cycle count-enable pulse to the counter
//   load     out  1  one-cycle parallel-load strobe to the counter
//   ld_hm    out  4  load value, hours tens
//   ld_hl    out  4  load value, hours units
//   ld_mm    out  4  load value, minutes tens
//   ld_ml    out  4  load value, minutes units (seconds are loaded as 00 by the counter on load)
//   blank    out  6  digit blank mask: [0]S_L [1]S_M [2]M_L [3]M_M [4]H_L [5]H_M; 1 = digit dark
//   state    out  2  FSM state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 COMMIT
// BEHAVIOUR
//   - Reset (rst=0, async): state=RUN, all outputs 0, edit regs 0, prescaler=0, blink phase=0, sync flops 0.
//   - Buttons: each passes through a 2-FF synchronizer plus a history flop; edge = s2 & ~s3.
//     If a button is sampled high at edge N, its edge pulse is high during N+1..N+2 and the FSM acts at N+2.
//     A held button gives exactly one edge. There is no debounce; inputs are debounced upstream.
//   - FSM transitions (all on a registered edge pulse):
//     RUN:     mode -> SET_HR; edit regs <= cur_* in the same cycle; prescaler <= 0
//     SET_HR:  inc -> hours += 1 (BCD); mode -> SET_MIN
//     SET_MIN: inc -> minutes += 1 (BCD); mode -> COMMIT
//     COMMIT:  unconditional -> RUN after exactly 1 cycle; load=1 for that cycle only
//     Edges on inc in RUN or COMMIT are ignored.
//   - Simultaneous mode and inc edges: mode wins; the inc edge is discarded.
//   - Hours increment: 23 -> 00; units 9 -> 0 with tens+1; any invalid value (tens>2, units>9, or >23) -> 00.
//   - Minutes increment: 59 -> 00; units 9 -> 0 with tens+1; any invalid value (tens>5 or units>9) -> 00.
//   - ld_*: continuously drive the edit regs, valid at least while load=1.
//   - Prescaler: counts 0..TICK_DIV-1 only in RUN. tick_en=1 in the cycle where count==TICK_DIV-1, then
//     count wraps to 0. In SET_HR, SET_MIN and COMMIT the count is held at 0 and tick_en=0.
//     First tick after COMMIT occurs TICK_DIV cycles after entry to RUN. tick_en and load never coexist.
//   - Blink: counter 0..BLINK_DIV-1 toggles phase on wrap and runs freely in all states.
//     blank[5:4]=phase in SET_HR; blank[3:2]=phase in SET_MIN; all other bits 0; blank=0 in RUN/COMMIT.
//   - Reset mid-edit: edits are discarded, no load is issued, state returns to RUN.
//   - All outputs are registered.
// TESTING (bench with TICK_DIV=4, BLINK_DIV=2)
//   1. Release reset, idle 20 cycles -> tick_en pulses every 4th cycle; load=0; blank=0; state=0.
//   2. cur=12:34, MODE pulse -> state=1 at N+2; ld=12:34; tick_en stays 0; blank toggles 6'b110000/0 every 2 cycles.
//   3. cur=22:58: MODE, INC x2, MODE, INC x3, MODE -> load=1 for 1 cycle with ld=00:01; state 3 -> 0;
//      first tick_en 4 cycles later.
//   4. Wrap/invalid: hours 23 + INC -> 00; minutes 59 + INC -> 00; cur_hm=4'hF captured, INC -> 00.
//   5. MODE and INC rise in the same cycle while in SET_HR -> state=2; hours unchanged.
//   6. Assert rst=0 asynchronously in SET_MIN -> all outputs 0 immediately, state=0, no load pulse after release.

Source files
------------

// File: rtl/rtc_set_ctrl.sv
// Time-set sequencer for the 24-hour BCD clock: 1 Hz prescaler, MODE/INC edit FSM,
// parallel-load strobe and per-digit blink mask for the six 7-segment digits.
module rtc_set_ctrl #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_hm,
   input  logic [3:0] cur_hl,
   input  logic [3:0] cur_mm,
   input  logic [3:0] cur_ml,
   output logic       tick_en,
   output logic       load,
   output logic [3:0] ld_hm,
   output logic [3:0] ld_hl,
   output logic [3:0] ld_mm,
   output logic [3:0] ld_ml,
   output logic [5:0] blank,
   output logic [1:0] state
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_SET_HR  = 2'd1;
   localparam logic [1:0] ST_SET_MIN = 2'd2;
   localparam logic [1:0] ST_COMMIT  = 2'd3;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   // Button synchronizers: [0] and [1] are the 2-FF synchronizer, [2] is the history flop.
   logic [2:0] mode_sync_q, mode_sync_d;
   logic [2:0] inc_sync_q, inc_sync_d;
   logic       mode_edge;
   logic       inc_edge;

   logic [1:0] state_q, state_d;
   logic [3:0] hm_q, hm_d;
   logic [3:0] hl_q, hl_d;
   logic [3:0] mm_q, mm_d;
   logic [3:0] ml_q, ml_d;

   logic [TW-1:0] pre_q, pre_d;
   logic          tick_q, tick_d;
   logic          load_q, load_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic [5:0]    blank_q, blank_d;

   // BCD hours increment, 23 wraps to 00; anything outside 00..23 also lands on 00.
   function automatic logic [7:0] hr_inc(input logic [3:0] t, input logic [3:0] u);
      logic [7:0] r;
      if (t > 4'd2 || u > 4'd9 || (t == 4'd2 && u >= 4'd3)) begin
         r = 8'h00;
      end else if (u == 4'd9) begin
         r = {t + 4'd1, 4'd0};
      end else begin
         r = {t, u + 4'd1};
      end
      return r;
   endfunction

   // BCD minutes increment, 59 wraps to 00; anything outside 00..59 also lands on 00.
   function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
      logic [7:0] r;
      if (t > 4'd5 || u > 4'd9 || (t == 4'd5 && u == 4'd9)) begin
         r = 8'h00;
      end else if (u == 4'd9) begin
         r = {t + 4'd1, 4'd0};
      end else begin
         r = {t, u + 4'd1};
      end
      return r;
   endfunction

   always_comb begin
      mode_sync_d = {mode_sync_q[1:0], btn_mode};
      inc_sync_d  = {inc_sync_q[1:0], btn_inc};
   end

   assign mode_edge = mode_sync_q[1] & ~mode_sync_q[2];
   assign inc_edge  = inc_sync_q[1] & ~inc_sync_q[2];

   // Edit FSM; a MODE edge always takes priority over a coincident INC edge.
   always_comb begin
      state_d = state_q;
      hm_d    = hm_q;
      hl_d    = hl_q;
      mm_d    = mm_q;
      ml_d    = ml_q;
      case (state_q)
         ST_RUN: begin
            if (mode_edge) begin
               state_d = ST_SET_HR;
               hm_d    = cur_hm;
               hl_d    = cur_hl;
               mm_d    = cur_mm;
               ml_d    = cur_ml;
            end
         end
         ST_SET_HR: begin
            if (mode_edge) begin
               state_d = ST_SET_MIN;
            end else if (inc_edge) begin
               {hm_d, hl_d} = hr_inc(hm_q, hl_q);
            end
         end
         ST_SET_MIN: begin
            if (mode_edge) begin
               state_d = ST_COMMIT;
            end else if (inc_edge) begin
               {mm_d, ml_d} = min_inc(mm_q, ml_q);
            end
         end
         ST_COMMIT: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Prescaler runs only while staying in RUN, so it restarts from 0 on every entry to RUN.
   always_comb begin
      pre_d = '0;
      if (state_q == ST_RUN && state_d == ST_RUN) begin
         pre_d = (pre_q == TICK_LAST) ? '0 : pre_q + TW'(1);
      end
      tick_d = (state_d == ST_RUN) && (pre_d == TICK_LAST);
      load_d = (state_d == ST_COMMIT);
   end

   // tick_en and load are single-cycle strobes with no back-pressure; ld_* hold steady while load=1.
   always_comb begin
      blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BW'(1);
      phase_d = phase_q ^ (blink_q == BLINK_LAST);
      case (state_d)
         ST_SET_HR:  blank_d = {phase_d, phase_d, 4'b0000};
         ST_SET_MIN: blank_d = {2'b00, phase_d, phase_d, 2'b00};
         default:    blank_d = 6'b000000;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_sync_q <= '0;
         inc_sync_q  <= '0;
         state_q     <= ST_RUN;
         hm_q        <= '0;
         hl_q        <= '0;
         mm_q        <= '0;
         ml_q        <= '0;
         pre_q       <= '0;
         tick_q      <= 1'b0;
         load_q      <= 1'b0;
         blink_q     <= '0;
         phase_q     <= 1'b0;
         blank_q     <= '0;
      end else begin
         mode_sync_q <= mode_sync_d;
         inc_sync_q  <= inc_sync_d;
         state_q     <= state_d;
         hm_q        <= hm_d;
         hl_q        <= hl_d;
         mm_q        <= mm_d;
         ml_q        <= ml_d;
         pre_q       <= pre_d;
         tick_q      <= tick_d;
         load_q      <= load_d;
         blink_q     <= blink_d;
         phase_q     <= phase_d;
         blank_q     <= blank_d;
      end
   end

   assign tick_en = tick_q;
   assign load    = load_q;
   assign ld_hm   = hm_q;
   assign ld_hl   = hl_q;
   assign ld_mm   = mm_q;
   assign ld_ml   = ml_q;
   assign blank   = blank_q;
   assign state   = state_q;

endmodule
